// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_flex: one synchronous write port and one
// asynchronous read port. The array is deliberately not reset; the parent
// guarantees a word is only read after it has been written.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the offered word into the addressed slot on the rising edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Head word is visible combinationally so the FIFO can fall through.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous first-word-fall-through FIFO with level reporting,
// almost-full / almost-empty thresholds and a synchronous flush.
//
// Handshake: a word moves across a port on a rising edge of comm_clock when
// valid and ready are both high in the cycle before that edge. ready/valid
// driven by this block depend only on registered pointer state, never
// combinationally on the partner's valid/ready. A producer must hold in_data
// while in_valid && !in_ready; out_data is held while out_valid && !out_ready.
module sync_fifo_flex #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_BITS          = 4,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_BITS) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  comm_clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  in_full,
  output logic                  in_almost_full,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_empty,
  output logic                  out_almost_empty,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_BITS:0]    level
);

  localparam int PTR_W = ADDR_BITS + 1;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(ALMOST_FULL_LEVEL);
  localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(ALMOST_EMPTY_LEVEL);

  // Pointers carry one extra MSB so that equal low bits can be told apart
  // as either empty (MSBs equal) or full (MSBs differ).
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Status is derived purely from the pointers, so it follows an
  // asynchronous reset immediately and always agrees with level.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
            (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  end

  assign level            = wr_ptr - rd_ptr;
  assign in_ready         = !full;
  assign in_full          = full;
  assign in_almost_full   = (level >= AF_LEVEL);
  assign out_valid        = !empty;
  assign out_empty        = empty;
  assign out_almost_empty = (level <= AE_LEVEL);

  // Flush wins over both ports; a full FIFO never passes a push through
  // even when a pop happens in the same cycle.
  assign push = in_valid && !full && !flush;
  assign pop  = out_ready && !empty && !flush;

  // Pointer update: flush returns both pointers to zero, otherwise each
  // advances by one on its own transfer with natural modulo wrap.
  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk     (comm_clock),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_BITS-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr[ADDR_BITS-1:0]),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex (default parameters: 8-bit words,
// depth 16, almost-full at 14, almost-empty at 2). A queue holds the words
// the bench expects to see, in push order; flags and level are checked
// every cycle against the queue size.
module tb_sync_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          comm_clock;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_full;
  logic          in_almost_full;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic          out_empty;
  logic          out_almost_empty;
  logic [DW-1:0] out_data;
  logic [4:0]    level;

  logic [DW-1:0] exp_q[$];
  int            checks;
  int            errors;

  sync_fifo_flex dut (
    .comm_clock       (comm_clock),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_full          (in_full),
    .in_almost_full   (in_almost_full),
    .in_data          (in_data),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_empty        (out_empty),
    .out_almost_empty (out_almost_empty),
    .out_data         (out_data),
    .level            (level)
  );

  // Clock / reset block
  initial begin
    comm_clock = 1'b0;
    forever #5 comm_clock = ~comm_clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output against the expected occupancy.
  task automatic check_status(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ":level"},     32'(level),            32'(n));
    check({tag, ":in_ready"},  32'(in_ready),         32'(n < DEPTH));
    check({tag, ":in_full"},   32'(in_full),          32'(n == DEPTH));
    check({tag, ":almost_f"},  32'(in_almost_full),   32'(n >= AF));
    check({tag, ":out_valid"}, 32'(out_valid),        32'(n > 0));
    check({tag, ":out_empty"}, 32'(out_empty),        32'(n == 0));
    check({tag, ":almost_e"},  32'(out_almost_empty), 32'(n <= AE));
    if (n > 0) begin
      check({tag, ":head"}, 32'(out_data), 32'(exp_q[0]));
    end
  endtask

  // Driver: apply one cycle of inputs (called just after a rising edge),
  // check pre-edge state, advance one edge and update the scoreboard.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic r, input logic f);
    logic          do_push;
    logic          do_pop;
    logic [DW-1:0] popped;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    check_status(tag);
    do_push = v && (exp_q.size() < DEPTH) && !f;
    do_pop  = r && (exp_q.size() > 0) && !f;
    if (do_pop) begin
      popped = exp_q.pop_front();
      check({tag, ":pop_data"}, 32'(out_data), 32'(popped));
    end
    @(posedge comm_clock);
    #1;
    if (f) begin
      exp_q.delete();
    end else if (do_push) begin
      exp_q.push_back(d);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state while reset is held
    #2;
    check_status("reset");
    @(posedge comm_clock);
    #1;
    reset = 1'b1;
    #1;

    // Two words, held, then popped in order
    cycle("t1_push_aa", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("t1_first_fall_through", 32'(out_data), 32'h0000_00AA);
    cycle("t1_push_bb", 1'b1, 8'hBB, 1'b0, 1'b0);
    cycle("t1_hold",    1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_level2", 32'(level), 32'd2);
    cycle("t1_pop_aa",  1'b0, 8'h00, 1'b1, 1'b0);
    cycle("t1_pop_bb",  1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_empty", 32'(out_empty), 32'd1);
    cycle("t1_idle_pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full, 17th push dropped, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      cycle("t2_fill", 1'b1, DW'(i), 1'b0, 1'b0);
    end
    check("t2_full", 32'(in_full), 32'd1);
    check("t2_level16", 32'(level), 32'd16);
    cycle("t2_drop_17th", 1'b1, 8'hEE, 1'b0, 1'b0);
    cycle("t2_full_hold_pop", 1'b1, 8'hEF, 1'b1, 1'b0);
    check("t2_no_passthrough", 32'(level), 32'd15);
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle("t2_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("t2_drained", 32'(out_empty), 32'd1);

    // Steady streaming at level 8 across pointer wrap
    for (int i = 0; i < 8; i++) begin
      cycle("t3_fill", 1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      cycle("t3_stream", 1'b1, DW'(8'h48 + i), 1'b1, 1'b0);
      check("t3_level8", 32'(level), 32'd8);
    end
    for (int i = 0; i < 8; i++) begin
      cycle("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Flush with a concurrent push
    for (int i = 0; i < 5; i++) begin
      cycle("t4_fill", 1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    cycle("t4_flush", 1'b1, 8'h77, 1'b1, 1'b1);
    check("t4_level0", 32'(level), 32'd0);
    check("t4_empty", 32'(out_empty), 32'd1);
    cycle("t4_after", 1'b1, 8'h12, 1'b0, 1'b0);
    cycle("t4_pop_new", 1'b0, 8'h00, 1'b1, 1'b0);

    // Thresholds on the way up to 14 and back down to 0
    for (int i = 0; i < AF; i++) begin
      cycle("t5_up", 1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    check("t5_af_at14", 32'(in_almost_full), 32'd1);
    for (int i = 0; i < AF; i++) begin
      cycle("t5_down", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("t5_ae_at0", 32'(out_almost_empty), 32'd1);

    // Asynchronous reset in mid-cycle with six words stored
    for (int i = 0; i < 6; i++) begin
      cycle("t6_fill", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    end
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_level", 32'(level), 32'd0);
    check_status("t6_async");
    #1;
    reset = 1'b1;
    @(posedge comm_clock);
    #1;
    cycle("t6_push_55", 1'b1, 8'h55, 1'b0, 1'b0);
    check("t6_out55", 32'(out_data), 32'h0000_0055);
    cycle("t6_pop_55", 1'b0, 8'h00, 1'b1, 1'b0);
    check_status("t6_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter ADDR_BITS, default 4, depth = 2**ADDR_BITS words (default 16); legal range 1..10.
REQ-003 Parameter ALMOST_FULL_LEVEL, default 2**ADDR_BITS-2, level at or above which in_almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_LEVEL, default 2, level at or below which out_almost_empty asserts.
REQ-005 comm_clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 flush  input  1  synchronous discard of all stored words.
REQ-008 in_valid  input  1  producer offers in_data.
REQ-009 in_ready  output  1  FIFO accepts a word this cycle.
REQ-010 in_full  output  1  level == depth.
REQ-011 in_almost_full  output  1  level >= ALMOST_FULL_LEVEL.
REQ-012 in_data  input  DATA_WIDTH  write word.
REQ-013 out_ready  input  1  consumer takes out_data.
REQ-014 out_valid  output  1  out_data holds a valid head word.
REQ-015 out_empty  output  1  level == 0.
REQ-016 out_almost_empty  output  1  level <= ALMOST_EMPTY_LEVEL.
REQ-017 out_data  output  DATA_WIDTH  head word (first-word-fall-through).
REQ-018 level  output  ADDR_BITS+1  number of stored words, 0..depth.

Function
REQ-019 Push occurs on a rising edge when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-020 in_ready = !in_full; out_valid = !out_empty; both derived from registered state only, no combinational path from in_valid/out_ready.
REQ-021 Pointers wr_ptr/rd_ptr are ADDR_BITS+1 bits; extra MSB distinguishes full from empty; full = MSBs differ, lower bits equal; wrap from depth-1 to 0 is natural modulo increment.
REQ-022 level = wr_ptr - rd_ptr modulo 2**(ADDR_BITS+1), registered or derived, always consistent with pointers in the same cycle.
REQ-023 Latency: word pushed at edge N is on out_data with out_valid=1 after edge N when FIFO was empty (one cycle, write-to-read).
REQ-024 out_data = storage[rd_ptr low bits]; stable while out_valid && !out_ready.
REQ-025 Simultaneous push and pop (non-empty, non-full): both occur, level unchanged.
REQ-026 Full: in_ready=0, in_valid ignored, no overwrite; pop-then-push needs two cycles (no full pass-through).
REQ-027 Empty: out_valid=0, out_ready ignored, pointers unchanged.
REQ-028 flush has priority over push and pop: next edge sets wr_ptr=rd_ptr=0, level=0; storage contents need not be cleared; concurrent push is dropped.
REQ-029 Order preserved: words leave in push order, DATA_WIDTH bits unmodified.

Reset
REQ-030 On reset=0, immediately (asynchronously): wr_ptr=0, rd_ptr=0, level=0, in_ready=1, in_full=0, in_almost_full=0, out_valid=0, out_empty=1, out_almost_empty=1.
REQ-031 Storage array is not reset; out_data is don't-care while out_valid=0.
REQ-032 Reset asserted mid-transfer discards all contents; first push after release behaves as from empty.

Structure
REQ-033 No shared package or typedefs; all sizing is local parameters/localparams (DEPTH derived from ADDR_BITS).
REQ-034 Storage is one sub-module sync_fifo_mem (DATA_WIDTH x DEPTH, one write port, one async read port); pointer, level and flag logic stay in sync_fifo_flex.

Verification
REQ-035 Reset, push 0xAA then 0xBB, hold out_ready=0 -> out_valid=1, out_data=0xAA, level=2; pop twice -> 0xAA, 0xBB, then out_empty=1, level=0.
REQ-036 Push 16 words 0x00..0x0F with out_ready=0 -> in_full=1, in_ready=0, level=16; 17th in_valid dropped; drain -> 0x00..0x0F in order.
REQ-037 Fill to 8, then 20 cycles continuous in_valid && out_ready with incrementing data -> level stays 8, output sequence uninterrupted, pointers wrap without gaps.
REQ-038 Fill to 5, assert flush with in_valid=1 for one cycle -> next cycle level=0, out_empty=1, flushed push not stored.
REQ-039 Thresholds: push to 14 -> in_almost_full=1 at level 14 only; pop to 2 -> out_almost_empty=1 at level 2 and below.
REQ-040 Assert reset=0 asynchronously mid-cycle with level=6 -> out_valid=0, level=0 before next edge; after release push 0x55 -> out_data=0x55 one cycle later.
